// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, FSM states,
// datapath mux encodings and the control word passed from the decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SL = 2'b11
    } alusrcb_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    typedef struct packed {
        logic     mem_req;
        logic     iord;
        logic     memwrite;
        logic     irwrite;
        logic     regdst;
        logic     memtoreg;
        logic     regwrite;
        logic     alusrca;
        alusrcb_t alusrcb;
        aluop_t   aluop;
        pcsrc_t   pcsrc;
        logic     pcwrite;
        logic     branch;
    } ctrl_t;

    // States that own the memory port and may stall on mem_ready.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// State-to-control-word decoder. Pure combinational; only irwrite/pcwrite in
// FETCH look at mem_ready, everything else is a function of the state alone.
module mips_mc_outdec
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: assigning the whole word first means every path drives every
        // bit, so no latch can be inferred and unlisted outputs read as 0.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMM_SL;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.branch  = 1'b1;
                ctrl.pcsrc   = PCSRC_ALUOUT;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            S_JEX: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with a shared memory port, mem_ready stalls,
// a memory watchdog and sticky halt/illegal-opcode flags.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcwrite,
    output logic       branch,
    output logic       halted,
    output logic       illegal_op
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic             wait_st;
    logic             timeout_hit;
    ctrl_t            ctrl;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;

        wait_st     = is_mem_wait(state_q);
        // The wait that would take the count to TIMEOUT is the last one allowed;
        // a mem_ready in that same cycle still completes the access.
        timeout_hit = (TIMEOUT != 0) && wait_st && !mem_ready && (cnt_q == TO_LAST);

        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_IDLE;
        endcase

        if (timeout_hit) begin
            state_d = S_TRAP;
        end
        if (state_d == S_TRAP) begin
            halted_d = 1'b1;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (wait_st && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; reset is asynchronous so it can abort a memory access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    mips_mc_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign mem_req    = ctrl.mem_req;
    assign iord       = ctrl.iord;
    assign memwrite   = ctrl.memwrite;
    assign irwrite    = ctrl.irwrite;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign regwrite   = ctrl.regwrite;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign aluop      = ctrl.aluop;
    assign pcsrc      = ctrl.pcsrc;
    assign pcwrite    = ctrl.pcwrite;
    assign branch     = ctrl.branch;
    assign halted     = halted_q;
    assign illegal_op = illegal_q;

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multicycle control FSM for the MIPS datapath. It replaces the single-cycle main decoder when the core shares one memory port for instructions and data. It sequences fetch, decode, execute, memory and writeback over several cycles and stalls on a memory ready handshake. The existing ALU decoder still consumes aluop.

Parameters:
TIMEOUT, 255, max cycles to wait for mem_ready in any memory state; 0 disables the watchdog
CNT_W, 8, watchdog counter width; must satisfy TIMEOUT < 2**CNT_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  opcode field from the instruction register
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access requested
iord  out  1  0 = address from PC, 1 = address from ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  load the instruction register
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = memory data, 0 = ALUOut
regwrite  out  1  register file write
alusrca  out  1  0 = PC, 1 = register A
alusrcb  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
aluop  out  2  00 = add, 01 = sub, 10 = decode funct
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pcwrite  out  1  unconditional PC write
branch  out  1  PC write qualified by zero
halted  out  1  sticky; set on an illegal opcode or a watchdog expiry
illegal_op  out  1  sticky; halt cause was an illegal opcode

Behaviour:
- The clock and reset are fixed as one clock (clk) with an asynchronous, active-low reset (rst_n).
- State register is 4 bits. rst_n low immediately forces IDLE, clears the watchdog and clears halted and illegal_op. This applies mid-access too; the memory side must tolerate mem_req dropping at any time.
- Every output defaults to 0. Each state drives only the outputs listed for it. Outputs are Moore except irwrite and pcwrite in FETCH.
- IDLE: all outputs 0. Go to FETCH next cycle.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
  - 000000 -> RTYPEEX
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other op -> TRAP, and set illegal_op
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD if op=100011, else MEMWR.
- MEMRD: mem_req=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Then FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1, held until mem_ready. Then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Then RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Then FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Then FETCH.
- JEX: pcsrc=10, pcwrite=1. Then FETCH.
- TRAP: all outputs 0 and halted=1. Only rst_n leaves TRAP.
- Watchdog:
  - The counter clears on entry to FETCH, MEMRD or MEMWR.
  - It increments each cycle spent in one of those states with mem_ready=0.
  - When TIMEOUT != 0 and the count reaches TIMEOUT with mem_ready still low, go to TRAP with illegal_op=0.
  - mem_ready=1 in the same cycle as the timeout wins: the access completes.
- op is sampled only in DECODE and MEMADR. Changes to op in other states are ignored.
- Instruction latency with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - the state enumeration (4-bit)
  - alusrcb, pcsrc and aluop encodings
- One natural sub-module: mips_mc_outdec, a combinational state-to-control-word decoder. It keeps the FSM and watchdog separate from the output table.

Test Plan:
- Reset release with op=000000 and mem_ready=1: one IDLE cycle with all outputs 0, then FETCH with irwrite=pcwrite=1, DECODE, RTYPEEX (aluop=10), RTYPEWB (regwrite=1, regdst=1), then back to FETCH.
- lw, op=100011, mem_ready low for 3 cycles in MEMRD: MEMRD holds mem_req=1, iord=1 for 4 cycles, then one MEMWB cycle with memtoreg=1, regwrite=1.
- sw, op=101011, mem_ready high: MEMWR asserts memwrite=1 for exactly 1 cycle, with regwrite=0 throughout.
- beq, then j: BEQEX asserts branch=1, pcsrc=01, aluop=01. JEX asserts pcwrite=1, pcsrc=10. Each instruction takes 3 cycles.
- Illegal op=111111: DECODE goes to TRAP, halted=1 and illegal_op=1, all strobes 0 for 20 cycles. rst_n pulse low clears both flags.
- TIMEOUT=4 with mem_ready stuck low in FETCH: TRAP after 4 wait cycles with halted=1 and illegal_op=0. Repeat with mem_ready=1 on the 4th cycle: DECODE is reached, no trap. Also assert rst_n low mid-MEMWR: mem_req and memwrite drop immediately.
